// File: rtl/sys_pkg.sv
// Shared encodings and default widths for the systolic processing element.
package sys_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MODE_OS = 1'b0;
  localparam logic MODE_WS = 1'b1;

  localparam int DEF_OPND_BWIDTH = 8;
  localparam int DEF_ACC_BWIDTH  = 32;
  localparam int DEF_SATURATE    = 1;

endpackage

// File: rtl/pe_sat_mac.sv
// Combinational signed multiply-add with overflow detect and optional clamping.
module pe_sat_mac
  import sys_pkg::*;
#(
  parameter int OPND_BWIDTH = DEF_OPND_BWIDTH,
  parameter int ACC_BWIDTH  = DEF_ACC_BWIDTH,
  parameter int SATURATE    = DEF_SATURATE
) (
  input  logic signed [OPND_BWIDTH-1:0] a,
  input  logic signed [OPND_BWIDTH-1:0] b,
  input  logic signed [ACC_BWIDTH-1:0]  addend,
  output logic signed [ACC_BWIDTH-1:0]  sum,
  output logic                          ovf
);

  localparam logic [ACC_BWIDTH-1:0] ACC_MAX = {1'b0, {(ACC_BWIDTH-1){1'b1}}};
  localparam logic [ACC_BWIDTH-1:0] ACC_MIN = {1'b1, {(ACC_BWIDTH-1){1'b0}}};

  logic signed [2*OPND_BWIDTH-1:0] w_prod;
  logic signed [ACC_BWIDTH:0]      w_sum;

  assign w_prod = (2*OPND_BWIDTH)'(a) * (2*OPND_BWIDTH)'(b);
  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign w_sum  = (ACC_BWIDTH+1)'(addend) + (ACC_BWIDTH+1)'(w_prod);
  assign ovf    = w_sum[ACC_BWIDTH] ^ w_sum[ACC_BWIDTH-1];

  always_comb begin
    sum = w_sum[ACC_BWIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      sum = w_sum[ACC_BWIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/sys_pe_v2.sv
// Systolic PE: output-stationary MAC with drain chain, or weight-stationary pass-through MAC.
module sys_pe_v2
  import sys_pkg::*;
#(
  parameter int OPND_BWIDTH = DEF_OPND_BWIDTH,
  parameter int ACC_BWIDTH  = DEF_ACC_BWIDTH,
  parameter int SATURATE    = DEF_SATURATE
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          STALL,
  input  logic                          START,
  input  logic                          FLUSH,
  input  logic                          LOAD_W,
  input  logic                          MODE,
  input  logic                          OPND1_valid_in,
  input  logic signed [OPND_BWIDTH-1:0] OPND1_in,
  input  logic                          OPND2_valid_in,
  input  logic signed [OPND_BWIDTH-1:0] OPND2_in,
  input  logic                          ACC_valid_in,
  input  logic signed [ACC_BWIDTH-1:0]  ACC_in,
  output logic                          OPND1_valid_out,
  output logic signed [OPND_BWIDTH-1:0] OPND1_out,
  output logic                          OPND2_valid_out,
  output logic signed [OPND_BWIDTH-1:0] OPND2_out,
  output logic                          ACC_valid_out,
  output logic signed [ACC_BWIDTH-1:0]  ACC_out,
  output logic                          BUSY,
  output logic                          OVF,
  output logic [1:0]                    o_dbg_state
);

  // Valid qualifies its data on the same cycle; there is no backpressure, only STALL.
  state_t                        r_state, w_state_nxt;
  logic                          r_mode, w_mode_nxt;
  logic signed [ACC_BWIDTH-1:0]  r_acc, w_acc_nxt;
  logic                          r_ovf, w_ovf_nxt;
  logic signed [OPND_BWIDTH-1:0] r_w, w_w_nxt;
  logic signed [ACC_BWIDTH-1:0]  r_acc_out, w_acc_out_nxt;
  logic                          r_acc_v, w_acc_v_nxt;
  logic signed [OPND_BWIDTH-1:0] r_opnd1, r_opnd2;
  logic                          r_opnd1_v, r_opnd2_v;

  logic signed [OPND_BWIDTH-1:0] w_mac_b;
  logic signed [ACC_BWIDTH-1:0]  w_mac_addend, w_mac_sum;
  logic                          w_mac_ovf;
  logic                          w_os_fire, w_ws_fire;

  assign w_mac_b      = (r_mode == MODE_WS) ? r_w : OPND2_in;
  assign w_mac_addend = (r_mode == MODE_WS) ? ACC_in : r_acc;
  assign w_os_fire    = OPND1_valid_in && OPND2_valid_in;
  assign w_ws_fire    = OPND1_valid_in && ACC_valid_in;

  pe_sat_mac #(
    .OPND_BWIDTH(OPND_BWIDTH),
    .ACC_BWIDTH (ACC_BWIDTH),
    .SATURATE   (SATURATE)
  ) u_mac (
    .a     (OPND1_in),
    .b     (w_mac_b),
    .addend(w_mac_addend),
    .sum   (w_mac_sum),
    .ovf   (w_mac_ovf)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_acc_nxt     = r_acc;
    w_ovf_nxt     = r_ovf;
    w_w_nxt       = r_w;
    w_acc_out_nxt = r_acc_out;
    w_acc_v_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_state_nxt = RUN;
          w_mode_nxt  = MODE;
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end else if (LOAD_W && OPND2_valid_in) begin
          w_w_nxt = OPND2_in;
        end
      end
      RUN: begin
        if (r_mode == MODE_OS) begin
          if (w_os_fire) begin
            w_acc_nxt = w_mac_sum;
            w_ovf_nxt = r_ovf | w_mac_ovf;
          end
          // A MAC landing on the flush edge is included in the emitted value.
          if (FLUSH) begin
            w_state_nxt   = DRAIN;
            w_acc_out_nxt = w_acc_nxt;
            w_acc_v_nxt   = 1'b1;
            w_acc_nxt     = '0;
          end
        end else begin
          if (w_ws_fire) begin
            w_acc_out_nxt = w_mac_sum;
            w_acc_v_nxt   = 1'b1;
            w_ovf_nxt     = r_ovf | w_mac_ovf;
          end
          if (FLUSH) w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        w_acc_out_nxt = ACC_in;
        w_acc_v_nxt   = ACC_valid_in;
        if (!FLUSH) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_mode    <= MODE_OS;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_w       <= '0;
      r_acc_out <= '0;
      r_acc_v   <= 1'b0;
      r_opnd1   <= '0;
      r_opnd2   <= '0;
      r_opnd1_v <= 1'b0;
      r_opnd2_v <= 1'b0;
    end else if (!STALL) begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_acc     <= w_acc_nxt;
      r_ovf     <= w_ovf_nxt;
      r_w       <= w_w_nxt;
      r_acc_out <= w_acc_out_nxt;
      r_acc_v   <= w_acc_v_nxt;
      r_opnd1_v <= OPND1_valid_in;
      r_opnd2_v <= OPND2_valid_in;
      if (OPND1_valid_in) r_opnd1 <= OPND1_in;
      if (OPND2_valid_in) r_opnd2 <= OPND2_in;
    end
  end

  assign OPND1_valid_out = r_opnd1_v;
  assign OPND1_out       = r_opnd1;
  assign OPND2_valid_out = r_opnd2_v;
  assign OPND2_out       = r_opnd2;
  assign ACC_valid_out   = r_acc_v;
  assign ACC_out         = r_acc_out;
  assign BUSY            = (r_state != IDLE);
  assign OVF             = r_ovf;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_sys_pe_v2.sv
// Directed bench: three chained 32-bit PEs plus 16-bit saturating and wrapping PEs.
module tb_sys_pe_v2;
  import sys_pkg::*;

  logic        clk, rst, stall, start, flush, load_w, mode, chain;
  logic [7:0]  a1 [3];
  logic [7:0]  a2 [3];
  logic        v1 [3];
  logic        v2 [3];
  logic [31:0] acc_in;
  logic        acc_v_in;

  logic [31:0] pe_acc_in [3];
  logic        pe_acc_v  [3];
  logic [7:0]  o1 [3];
  logic [7:0]  o2 [3];
  logic        o1v [3];
  logic        o2v [3];
  logic [31:0] aout [3];
  logic        aov [3];
  logic        busy [3];
  logic        ovf [3];
  logic [1:0]  st [3];

  logic [7:0]  sat_o1, sat_o2, wrp_o1, wrp_o2;
  logic        sat_o1v, sat_o2v, sat_aov, sat_busy, sat_ovf;
  logic        wrp_o1v, wrp_o2v, wrp_aov, wrp_busy, wrp_ovf;
  logic [15:0] sat_aout, wrp_aout;
  logic [1:0]  sat_st, wrp_st;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    pe_acc_in[0] = acc_in;
    pe_acc_v[0]  = acc_v_in;
    for (int i = 1; i < 3; i++) begin
      pe_acc_in[i] = chain ? aout[i-1] : acc_in;
      pe_acc_v[i]  = chain ? aov[i-1]  : acc_v_in;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_pe
    sys_pe_v2 #(.OPND_BWIDTH(8), .ACC_BWIDTH(32), .SATURATE(1)) u_pe (
      .CLK(clk), .RST(rst), .STALL(stall), .START(start), .FLUSH(flush),
      .LOAD_W(load_w), .MODE(mode),
      .OPND1_valid_in(v1[g]), .OPND1_in(a1[g]),
      .OPND2_valid_in(v2[g]), .OPND2_in(a2[g]),
      .ACC_valid_in(pe_acc_v[g]), .ACC_in(pe_acc_in[g]),
      .OPND1_valid_out(o1v[g]), .OPND1_out(o1[g]),
      .OPND2_valid_out(o2v[g]), .OPND2_out(o2[g]),
      .ACC_valid_out(aov[g]), .ACC_out(aout[g]),
      .BUSY(busy[g]), .OVF(ovf[g]), .o_dbg_state(st[g])
    );
  end

  sys_pe_v2 #(.OPND_BWIDTH(8), .ACC_BWIDTH(16), .SATURATE(1)) u_sat (
    .CLK(clk), .RST(rst), .STALL(stall), .START(start), .FLUSH(flush),
    .LOAD_W(load_w), .MODE(mode),
    .OPND1_valid_in(v1[2]), .OPND1_in(a1[2]),
    .OPND2_valid_in(v2[2]), .OPND2_in(a2[2]),
    .ACC_valid_in(acc_v_in), .ACC_in(acc_in[15:0]),
    .OPND1_valid_out(sat_o1v), .OPND1_out(sat_o1),
    .OPND2_valid_out(sat_o2v), .OPND2_out(sat_o2),
    .ACC_valid_out(sat_aov), .ACC_out(sat_aout),
    .BUSY(sat_busy), .OVF(sat_ovf), .o_dbg_state(sat_st)
  );

  sys_pe_v2 #(.OPND_BWIDTH(8), .ACC_BWIDTH(16), .SATURATE(0)) u_wrp (
    .CLK(clk), .RST(rst), .STALL(stall), .START(start), .FLUSH(flush),
    .LOAD_W(load_w), .MODE(mode),
    .OPND1_valid_in(v1[2]), .OPND1_in(a1[2]),
    .OPND2_valid_in(v2[2]), .OPND2_in(a2[2]),
    .ACC_valid_in(acc_v_in), .ACC_in(acc_in[15:0]),
    .OPND1_valid_out(wrp_o1v), .OPND1_out(wrp_o1),
    .OPND2_valid_out(wrp_o2v), .OPND2_out(wrp_o2),
    .ACC_valid_out(wrp_aov), .ACC_out(wrp_aout),
    .BUSY(wrp_busy), .OVF(wrp_ovf), .o_dbg_state(wrp_st)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ops(input logic [7:0] x, input logic xv, input logic [7:0] y, input logic yv);
    for (int i = 0; i < 3; i++) begin
      a1[i] = x; v1[i] = xv;
      a2[i] = y; v2[i] = yv;
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; stall = 1'b0; start = 1'b0; flush = 1'b0;
    load_w = 1'b0; mode = MODE_OS; chain = 1'b0;
    acc_in = '0; acc_v_in = 1'b0;
    ops(8'd0, 1'b0, 8'd0, 1'b0);

    // reset state
    step(); step();
    chk("rst_acc", aout[2], 0);
    chk("rst_accv", aov[2], 0);
    chk("rst_busy", busy[2], 0);
    chk("rst_ovf", ovf[2], 0);
    rst = 1'b0;
    step();
    chk("idle_busy", busy[2], 0);

    // output-stationary job: 2*3 + (-4)*5 + 7*7 = 35
    mode = MODE_OS; start = 1'b1; step(); start = 1'b0;
    chk("os_busy", busy[2], 1);
    chk("os_state", st[2], RUN);
    ops(8'd2, 1'b1, 8'd3, 1'b1); step();
    chk("fwd1", o1[2], 2);
    chk("fwd1v", o1v[2], 1);
    chk("fwd2", o2[2], 3);
    ops(8'hFC, 1'b1, 8'd5, 1'b1); step();
    ops(8'd7, 1'b1, 8'd7, 1'b1); step();
    ops(8'd9, 1'b1, 8'd0, 1'b0); step();
    chk("os_accv_run", aov[2], 0);
    chk("fwd2v_low", o2v[2], 0);
    ops(8'd0, 1'b0, 8'd0, 1'b0); step();
    chk("hold1", o1[2], 9);
    chk("hold1v", o1v[2], 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("os_acc", aout[2], 35);
    chk("os_accv", aov[2], 1);
    chk("os_drain", st[2], DRAIN);
    step();
    chk("os_accv_once", aov[2], 0);
    chk("os_idle", busy[2], 0);

    // weight-stationary: 100 + 4*(-3) = 88
    load_w = 1'b1; ops(8'd0, 1'b0, 8'hFD, 1'b1); step();
    load_w = 1'b0; ops(8'd0, 1'b0, 8'd0, 1'b0);
    chk("w_fwd", o2[2], 8'hFD);
    mode = MODE_WS; start = 1'b1; step(); start = 1'b0; mode = MODE_OS;
    chk("ws_busy", busy[2], 1);
    ops(8'd4, 1'b1, 8'd0, 1'b0); acc_in = 32'd100; acc_v_in = 1'b1; step();
    ops(8'd0, 1'b0, 8'd0, 1'b0); acc_v_in = 1'b0;
    chk("ws_acc", aout[2], 88);
    chk("ws_accv", aov[2], 1);
    step();
    chk("ws_accv_low", aov[2], 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("ws_flush_idle", busy[2], 0);
    chk("ws_flush_nov", aov[2], 0);

    // saturation and wrap: ten MACs of 127*127 = 161290
    acc_in = '0;
    mode = MODE_OS; start = 1'b1; step(); start = 1'b0;
    repeat (10) begin
      ops(8'd127, 1'b1, 8'd127, 1'b1); step();
    end
    ops(8'd0, 1'b0, 8'd0, 1'b0);
    chk("sat_ovf", sat_ovf, 1);
    chk("wrp_ovf", wrp_ovf, 1);
    chk("big_ovf", ovf[2], 0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("sat_acc", sat_aout, 32767);
    chk("wrp_acc", wrp_aout, 30218);
    chk("big_acc", aout[2], 161290);
    step();
    chk("sat_ovf_sticky", sat_ovf, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("sat_ovf_clr", sat_ovf, 0);
    chk("wrp_ovf_clr", wrp_ovf, 0);
    flush = 1'b1; step(); flush = 1'b0; step();

    // stall for 4 cycles mid-stream; inputs during the stall are ignored
    start = 1'b1; step(); start = 1'b0;
    ops(8'd2, 1'b1, 8'd3, 1'b1); step();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ops(8'(50 + k), 1'b1, 8'd60, 1'b1);
      flush = (k == 2);
      step();
      chk("stall_o1", o1[2], 2);
      chk("stall_o2", o2[2], 3);
      chk("stall_busy", busy[2], 1);
      chk("stall_accv", aov[2], 0);
    end
    stall = 1'b0; flush = 1'b0;
    ops(8'hFC, 1'b1, 8'd5, 1'b1); step();
    ops(8'd7, 1'b1, 8'd7, 1'b1); step();
    ops(8'd0, 1'b0, 8'd0, 1'b0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("stall_acc", aout[2], 35);
    step();

    // drain chain: accs 10, 20, 30; tail emits 30, 20, 10
    chain = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    a1[0] = 8'd10; a1[1] = 8'd20; a1[2] = 8'd30;
    for (int i = 0; i < 3; i++) begin
      a2[i] = 8'd1; v1[i] = 1'b1; v2[i] = 1'b1;
    end
    step();
    ops(8'd0, 1'b0, 8'd0, 1'b0);
    flush = 1'b1; step();
    chk("chain_30", aout[2], 30);
    chk("chain_30v", aov[2], 1);
    step();
    chk("chain_20", aout[2], 20);
    chk("chain_20v", aov[2], 1);
    step();
    chk("chain_10", aout[2], 10);
    chk("chain_10v", aov[2], 1);
    flush = 1'b0; step();
    chk("chain_endv", aov[2], 0);
    chk("chain_idle", busy[2], 0);
    chain = 1'b0;

    // START wins over FLUSH in IDLE; then reset lands mid-DRAIN
    start = 1'b1; flush = 1'b1; step(); start = 1'b0; flush = 1'b0;
    chk("sf_run", st[2], RUN);
    ops(8'd5, 1'b1, 8'd5, 1'b1); step();
    ops(8'd0, 1'b0, 8'd0, 1'b0);
    flush = 1'b1; step();
    chk("rd_acc", aout[2], 25);
    step();
    chk("rd_drain", st[2], DRAIN);
    rst = 1'b1; #1;
    chk("rd_rst_acc", aout[2], 0);
    chk("rd_rst_accv", aov[2], 0);
    chk("rd_rst_busy", busy[2], 0);
    chk("rd_rst_o1", o1[2], 0);
    chk("rd_rst_state", st[2], IDLE);
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) flush = 1'b0;
      step();
      chk("rd_no_accv", aov[2], 0);
      chk("rd_idle", busy[2], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
